arm_alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational ARM data-processing ALU.
- Executes all 16 ARM data-processing opcodes in one cycle. Adds an iterative shift-add multiplier (MUL/MLA) and an internal NZCV flag register with ARM-correct carry/borrow semantics.
- Input/output use valid/ready handshakes; sits between the register-file read stage and the writeback stage of the pipelined core.

---
 rtl/arm_alu_seq_if.sv | 53 +++++
 rtl/arm_alu_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_arm_alu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_alu_seq_if.sv
// ---------------------------------------------------------------------------
// arm_alu_seq_if
// Handshake and data bundle between the register-file read stage, the
// registered ARM data-processing ALU and the writeback stage.
//
// Upstream (issue side):
//   in_valid/in_ready       operation handshake
//   op_code, mul, acc       operation select (ALU opcode, MUL, MLA)
//   set_flags, shifter_c    S bit and barrel-shifter carry-out
//   dataA, dataB, dataC     Rn, shifter operand, accumulator
// Downstream (writeback side):
//   out_valid/out_ready     result handshake
//   result, wr_en           registered result and register-write enable
//   N/Z/C/V_flag            architectural flag register
//
// The master modport is the surrounding pipeline; the slave modport is the ALU.
// ---------------------------------------------------------------------------
interface arm_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op_code;
    logic             mul;
    logic             acc;
    logic             set_flags;
    logic             shifter_c;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] dataC;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wr_en;
    logic             N_flag;
    logic             Z_flag;
    logic             C_flag;
    logic             V_flag;

    modport master (
        output in_valid, op_code, mul, acc, set_flags, shifter_c,
               dataA, dataB, dataC, out_ready,
        input  in_ready, out_valid, result, wr_en,
               N_flag, Z_flag, C_flag, V_flag
    );

    modport slave (
        input  in_valid, op_code, mul, acc, set_flags, shifter_c,
               dataA, dataB, dataC, out_ready,
        output in_ready, out_valid, result, wr_en,
               N_flag, Z_flag, C_flag, V_flag
    );
endinterface

// File: rtl/arm_alu_seq.sv
// ---------------------------------------------------------------------------
// arm_alu_seq
// Registered ARM data-processing ALU with an iterative shift-add multiplier
// (MUL/MLA) and an internal NZCV flag register.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      arm_alu_seq_if.slave: valid/ready operation input, valid/ready
//            result output, wr_en and the N/Z/C/V flag register
//
// ALU ops complete with latency 1 and may issue back to back. A multiply
// occupies the block for WIDTH cycles (one partial product per cycle) and
// its result appears WIDTH+1 cycles after accept.
// ---------------------------------------------------------------------------
module arm_alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    arm_alu_seq_if.slave bus
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             in_ready;
    logic             mul_req;
    logic             accept;
    logic             alu_load;
    logic             mul_start;
    logic             mul_done;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             wr_en_q;
    logic             n_q;
    logic             z_q;
    logic             c_q;
    logic             v_q;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic             is_arith;
    logic             is_test;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic [WIDTH-1:0] mul_c_q;
    logic             mul_acc_q;
    logic             mul_s_q;
    logic [WIDTH-1:0] mul_prod_q;
    logic [CNT_W-1:0] mul_cnt_q;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] mul_final;

    // With the multiplier compiled out the mul input is simply ignored.
    assign mul_req   = MUL_EN && bus.mul;
    assign accept    = bus.in_valid && in_ready;
    assign alu_load  = accept && !mul_req;
    assign mul_start = accept && mul_req;
    assign mul_done  = (state == MUL) && (mul_cnt_q == LAST_ITER);

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a multiply holds the block until its last iteration.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mul_start) state_next = MUL;
            MUL:  if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: accept when idle and the result slot is free or being
    // drained this cycle, so consecutive ALU ops issue without a bubble.
    always_comb begin
        in_ready = 1'b0;
        if (reset_n && (state == IDLE)) begin
            in_ready = !out_valid_q || bus.out_ready;
        end
    end

    // Single-cycle datapath. Subtracts are formed as x + ~y + cin so that
    // the carry out is the ARM "no borrow" carry, and V is computed from the
    // operands actually fed to the adder. Logical ops take C from the
    // barrel shifter and leave V alone.
    always_comb begin
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        is_arith  = 1'b0;
        logic_res = '0;
        case (bus.op_code)
            OP_AND, OP_TST: logic_res = bus.dataA & bus.dataB;
            OP_EOR, OP_TEQ: logic_res = bus.dataA ^ bus.dataB;
            OP_ORR:         logic_res = bus.dataA | bus.dataB;
            OP_MOV:         logic_res = bus.dataB;
            OP_BIC:         logic_res = bus.dataA & ~bus.dataB;
            OP_MVN:         logic_res = ~bus.dataB;
            OP_SUB, OP_CMP: begin
                add_x = bus.dataA;  add_y = ~bus.dataB; add_cin = 1'b1; is_arith = 1'b1;
            end
            OP_RSB: begin
                add_x = bus.dataB;  add_y = ~bus.dataA; add_cin = 1'b1; is_arith = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                add_x = bus.dataA;  add_y = bus.dataB;  add_cin = 1'b0; is_arith = 1'b1;
            end
            OP_ADC: begin
                add_x = bus.dataA;  add_y = bus.dataB;  add_cin = c_q;  is_arith = 1'b1;
            end
            OP_SBC: begin
                add_x = bus.dataA;  add_y = ~bus.dataB; add_cin = c_q;  is_arith = 1'b1;
            end
            OP_RSC: begin
                add_x = bus.dataB;  add_y = ~bus.dataA; add_cin = c_q;  is_arith = 1'b1;
            end
            default: logic_res = '0;
        endcase

        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

        if (is_arith) begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                      (sum[WIDTH-1] != add_x[WIDTH-1]);
        end else begin
            alu_res = logic_res;
            alu_c   = bus.shifter_c;
            alu_v   = v_q;
        end

        // TST/TEQ/CMP/CMN share the 10xx opcode quadrant.
        is_test = (bus.op_code[3:2] == 2'b10);
    end

    // Shift-add step: A is pre-shifted and B consumed LSB first, so each
    // cycle only needs a conditional add. The accumulator joins on the
    // final iteration.
    assign mul_sum   = mul_prod_q + (mul_b_q[0] ? mul_a_q : '0);
    assign mul_final = mul_sum + (mul_acc_q ? mul_c_q : '0);

    // Multiplier operand and partial-product registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_c_q    <= '0;
            mul_acc_q  <= 1'b0;
            mul_s_q    <= 1'b0;
            mul_prod_q <= '0;
            mul_cnt_q  <= '0;
        end else if (mul_start) begin
            mul_a_q    <= bus.dataA;
            mul_b_q    <= bus.dataB;
            mul_c_q    <= bus.dataC;
            mul_acc_q  <= bus.acc;
            mul_s_q    <= bus.set_flags;
            mul_prod_q <= '0;
            mul_cnt_q  <= '0;
        end else if (state == MUL) begin
            mul_a_q    <= mul_a_q << 1;
            mul_b_q    <= mul_b_q >> 1;
            mul_prod_q <= mul_sum;
            mul_cnt_q  <= mul_done ? '0 : mul_cnt_q + 1'b1;
        end
    end

    // Result and flag registers. Flags commit on the same edge as the
    // result, so an ADC/SBC/RSC issued next cycle sees the new C.
    // A multiply only touches N and Z.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wr_en_q     <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else if (alu_load) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            wr_en_q     <= !is_test;
            if (bus.set_flags || is_test) begin
                n_q <= alu_res[WIDTH-1];
                z_q <= (alu_res == '0);
                c_q <= alu_c;
                v_q <= alu_v;
            end
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_final;
            wr_en_q     <= 1'b1;
            if (mul_s_q) begin
                n_q <= mul_final[WIDTH-1];
                z_q <= (mul_final == '0);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.N_flag    = n_q;
    assign bus.Z_flag    = z_q;
    assign bus.C_flag    = c_q;
    assign bus.V_flag    = v_q;

endmodule

// File: tb/tb_arm_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_arm_alu_seq
// Directed bench for arm_alu_seq (WIDTH=32, MUL_EN=1): a table of
// back-to-back ALU vectors with hand-computed results and NZCV, followed by
// multiply, output-stall and reset-during-multiply sequences.
// ---------------------------------------------------------------------------
module tb_arm_alu_seq;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic         s;
        logic         sc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         wr;
        logic [3:0]   nzcv;
    } vec_t;

    localparam int NVEC = 20;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NVEC];

    arm_alu_seq_if #(.WIDTH(W)) bus ();

    arm_alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.N_flag, bus.Z_flag, bus.C_flag, bus.V_flag};
    endfunction

    // Single comparison: counts it and reports a miscompare.
    task automatic checkOutput(input string name, input logic [W-1:0] got,
                               input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Presents one ALU op at the current negedge, lets it be accepted on the
    // next rising edge and returns at the following negedge.
    task automatic applyStimulus(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.mul       = 1'b0;
        bus.acc       = 1'b0;
        bus.op_code   = v.op;
        bus.set_flags = v.s;
        bus.shifter_c = v.sc;
        bus.dataA     = v.a;
        bus.dataB     = v.b;
        bus.dataC     = '0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs a MUL/MLA and checks busy time, latency, result and flags.
    task automatic runMul(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic acc, input logic s,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_nzcv);
        int latency;
        int busy;
        latency = 0;
        busy    = 0;
        bus.in_valid  = 1'b1;
        bus.mul       = 1'b1;
        bus.acc       = acc;
        bus.set_flags = s;
        bus.op_code   = 4'h0;
        bus.dataA     = a;
        bus.dataB     = b;
        bus.dataC     = c;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mul      = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.out_valid) begin
                latency = k;
                break;
            end
            if (!bus.in_ready) busy++;
            @(negedge clk);
        end
        checkOutput({name, " latency"}, W'(latency), W'(W + 1));
        checkOutput({name, " in_ready low"}, W'(busy), W'(W));
        checkOutput({name, " result"}, bus.result, exp_res);
        checkOutput({name, " wr_en"}, W'(bus.wr_en), W'(1));
        checkOutput({name, " nzcv"}, W'(flags()), W'(exp_nzcv));
        @(negedge clk);
    endtask

    initial begin
        int rises;
        n_checks = 0;
        n_fail   = 0;

        // Sequential vectors; NZCV carries over from one row to the next.
        //              op     s     sc    a             b             result        wr    nzcv
        vecs[0]  = '{4'h4, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 4'b1001}; // ADDS overflow
        vecs[1]  = '{4'hA, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 4'b0110}; // CMP 5,5
        vecs[2]  = '{4'h6, 1'b1, 1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b1, 4'b0010}; // SBCS C=1
        vecs[3]  = '{4'h5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 4'b0010}; // ADCS C=1
        vecs[4]  = '{4'h2, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 4'b1000}; // SUBS borrow
        vecs[5]  = '{4'h3, 1'b1, 1'b0, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'b0011}; // RSBS overflow
        vecs[6]  = '{4'h7, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0005, 32'h0000_0003, 1'b1, 4'b0010}; // RSCS C=1
        vecs[7]  = '{4'h6, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0110}; // SBCS 0,0 C=1
        vecs[8]  = '{4'h2, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 4'b1000}; // SUBS 0-1
        vecs[9]  = '{4'h6, 1'b1, 1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 1'b1, 4'b0010}; // SBCS C=0
        vecs[10] = '{4'hD, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0110}; // MOVS 0
        vecs[11] = '{4'h1, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 4'b0110}; // EOR no S
        vecs[12] = '{4'h8, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 1'b0, 4'b0100}; // TST
        vecs[13] = '{4'h9, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 4'b1010}; // TEQ
        vecs[14] = '{4'hB, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 4'b0111}; // CMN
        vecs[15] = '{4'hC, 1'b1, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b1, 4'b0001}; // ORRS
        vecs[16] = '{4'hE, 1'b1, 1'b1, 32'hFFFF_00FF, 32'h0000_00F0, 32'hFFFF_000F, 1'b1, 4'b1011}; // BICS
        vecs[17] = '{4'hF, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b0101}; // MVNS
        vecs[18] = '{4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_BEEF, 1'b1, 4'b0101}; // AND no S
        vecs[19] = '{4'h5, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b1, 4'b0101}; // ADC C=0

        bus.in_valid  = 1'b0;
        bus.mul       = 1'b0;
        bus.acc       = 1'b0;
        bus.op_code   = 4'h0;
        bus.set_flags = 1'b0;
        bus.shifter_c = 1'b0;
        bus.dataA     = '0;
        bus.dataB     = '0;
        bus.dataC     = '0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;

        // Reset state.
        #1;
        checkOutput("reset out_valid", W'(bus.out_valid), W'(0));
        checkOutput("reset result", bus.result, W'(0));
        checkOutput("reset wr_en", W'(bus.wr_en), W'(0));
        checkOutput("reset nzcv", W'(flags()), W'(4'b0000));
        checkOutput("reset in_ready", W'(bus.in_ready), W'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready", W'(bus.in_ready), W'(1));

        // Back-to-back ALU vectors, one accept per cycle.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d out_valid", i), W'(bus.out_valid), W'(1));
            checkOutput($sformatf("vec%0d result", i), bus.result, vecs[i].res);
            checkOutput($sformatf("vec%0d wr_en", i), W'(bus.wr_en), W'(vecs[i].wr));
            checkOutput($sformatf("vec%0d nzcv", i), W'(flags()), W'(vecs[i].nzcv));
        end
        bus.in_valid = 1'b0;

        // Multiplies: C and V stay at 0/1 from the table.
        runMul("MLA",      32'h0000_1234, 32'h0000_0010, 32'h0000_0005, 1'b1, 1'b1, 32'h0001_2345, 4'b0001);
        runMul("MUL 7*6",  32'h0000_0007, 32'h0000_0006, 32'h0000_0099, 1'b0, 1'b0, 32'h0000_002A, 4'b0001);
        runMul("MUL ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 4'b0001);
        runMul("MUL zero", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b0101);

        // Output stall: AND result held while out_ready is low, a pending
        // ADD must wait and then issue on the first ready cycle.
        bus.out_ready = 1'b0;
        applyStimulus('{4'h0, 1'b0, 1'b0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 1'b1, 4'b0101});
        checkOutput("stall AND result", bus.result, 32'h0000_0F00);
        bus.op_code = 4'h4;
        bus.dataA   = 32'h1;
        bus.dataB   = 32'h1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("stall%0d in_ready", k), W'(bus.in_ready), W'(0));
            checkOutput($sformatf("stall%0d held", k),
                        W'(bus.out_valid && bus.wr_en && (bus.result == 32'h0000_0F00)), W'(1));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("stall release in_ready", W'(bus.in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("stall ADD result", bus.result, 32'h0000_0002);
        checkOutput("stall ADD out_valid", W'(bus.out_valid), W'(1));
        checkOutput("stall ADD nzcv", W'(flags()), W'(4'b0101));
        @(negedge clk);

        // Reset asserted in the tenth multiply cycle.
        bus.in_valid  = 1'b1;
        bus.mul       = 1'b1;
        bus.set_flags = 1'b1;
        bus.dataA     = 32'h3;
        bus.dataB     = 32'h4;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mul      = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mul reset in_ready", W'(bus.in_ready), W'(0));
        checkOutput("mul reset out_valid", W'(bus.out_valid), W'(0));
        checkOutput("mul reset nzcv", W'(flags()), W'(4'b0000));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("mul release in_ready", W'(bus.in_ready), W'(1));
        rises = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) rises++;
        end
        checkOutput("mul abort out_valid", W'(rises), W'(0));
        checkOutput("mul abort nzcv", W'(flags()), W'(4'b0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
